// File: rtl/e_unary_enc_skid.sv
// e_unary_enc_skid: generic two-entry valid/ready pipeline register (OUT + SKD).
// o_rdy is registered and the output side is fed only from flops.
`default_nettype none

module e_unary_enc_skid #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic [DW-1:0] i_data,
    output logic          o_vld,
    input  logic          i_rdy,
    output logic [DW-1:0] o_data
);

    // Encoding is {SKD valid, OUT valid}; SKD is never valid while OUT is empty.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            rdy_q, rdy_d;
    logic [DW-1:0]   out_q, out_d;
    logic [DW-1:0]   skd_q, skd_d;
    logic            acc;
    logic            xfer;

    assign o_vld  = (state_q != ST_EMPTY);
    assign o_rdy  = rdy_q;
    assign o_data = out_q;
    assign acc    = i_vld & rdy_q;
    assign xfer   = o_vld & i_rdy;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skd_d   = skd_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d = ST_ONE;
                    out_d   = i_data;
                end
            end
            ST_ONE: begin
                if (acc && xfer) begin
                    out_d = i_data;
                end else if (acc) begin
                    state_d = ST_FULL;
                    skd_d   = i_data;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    state_d = ST_ONE;
                    out_d   = skd_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        rdy_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
            out_q   <= '0;
            skd_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            out_q   <= out_d;
            skd_q   <= skd_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/e_unary_enc.sv
// e_unary_enc: streaming binary-to-unary (thermometer) encoder with optional
// complement form, range check, saturating error counter and skid-buffered output.
`default_nettype none

module e_unary_enc #(
    parameter int W                    = 16,
    parameter int P_EMIT_COMPLIMENT_EN = 1,
    parameter int P_ERR_CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   i_vld,
    input  logic [$clog2(W):0]     i_n,
    input  logic                   i_cpl,
    output logic                   o_rdy,
    output logic                   o_vld,
    input  logic                   i_rdy,
    output logic [W-1:0]           o_code,
    output logic                   o_cpl,
    output logic                   o_err,
    output logic [P_ERR_CNT_W-1:0] o_err_cnt
);

    localparam int NW = $clog2(W) + 1;
    localparam int EW = W + 2;

    logic [W-1:0]           std_code;
    logic [W-1:0]           enc_code;
    logic                   enc_cpl;
    logic                   enc_err;
    logic [EW-1:0]          enc_entry;
    logic [EW-1:0]          out_entry;
    logic                   acc;
    logic [P_ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        std_code = '0;
        for (int k = 0; k < W; k++) begin
            std_code[k] = (k < int'(i_n));
        end
        enc_err = (int'(i_n) >= W);
        enc_cpl = i_cpl & (P_EMIT_COMPLIMENT_EN != 0);
        // Error entries carry a zero code in standard form regardless of the request.
        if (enc_err) begin
            enc_code = '0;
            enc_cpl  = 1'b0;
        end else if (enc_cpl) begin
            enc_code = ~std_code;
        end else begin
            enc_code = std_code;
        end
    end

    assign enc_entry = {enc_err, enc_cpl, enc_code};
    assign acc       = i_vld & o_rdy;

    e_unary_enc_skid #(
        .DW (EW)
    ) u_skid (
        .clk    (clk),
        .arst_n (arst_n),
        .i_vld  (i_vld),
        .o_rdy  (o_rdy),
        .i_data (enc_entry),
        .o_vld  (o_vld),
        .i_rdy  (i_rdy),
        .o_data (out_entry)
    );

    assign o_err  = out_entry[EW-1];
    assign o_cpl  = out_entry[EW-2];
    assign o_code = out_entry[W-1:0];

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (acc && enc_err && (err_cnt_q != {P_ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + P_ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;

    // NW is the declared count width; kept for readers matching port sizing.
    if (NW != $clog2(W) + 1) begin : g_nw_guard
        $error("count width mismatch");
    end

endmodule

`default_nettype wire
